// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage request and hazard-control response bundle
interface hazard_ctrl_if;
  logic       id_valid_i;
  logic [4:0] id_rs1_idx_i;
  logic [4:0] id_rs2_idx_i;
  logic       id_rs1_used_i;
  logic       id_rs2_used_i;
  logic [4:0] id_rd_addr_i;
  logic       id_rd_wr_i;
  logic       id_is_load_i;
  logic       ex_redirect_i;
  logic       stall_o;
  logic       flush_id_o;
  logic [1:0] fwd_rs1_sel_o;
  logic [1:0] fwd_rs2_sel_o;

  // Pipeline side: presents the ID instruction and redirect, consumes controls
  modport master (
    output id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs1_used_i, id_rs2_used_i,
    output id_rd_addr_i, id_rd_wr_i, id_is_load_i, ex_redirect_i,
    input  stall_o, flush_id_o, fwd_rs1_sel_o, fwd_rs2_sel_o
  );

  // Hazard controller side
  modport slave (
    input  id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs1_used_i, id_rs2_used_i,
    input  id_rd_addr_i, id_rd_wr_i, id_is_load_i, ex_redirect_i,
    output stall_o, flush_id_o, fwd_rs1_sel_o, fwd_rs2_sel_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, redirect flush and forwarding select control
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  // EX and MEM shadow slots. The WB slot is only ever consulted at the edge
  // it is formed (to pick select 2), so it lives on inside the registered
  // forwarding selects rather than as separate state. Likewise EX source
  // indices are consumed when the selects are registered.
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_wr_q, ex_wr_d;
  logic       ex_load_q, ex_load_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;

  logic [1:0] fwd1_q, fwd1_d;
  logic [1:0] fwd2_q, fwd2_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  state_t     state_q;
  logic [3:0] fcnt_q;

  logic ex_wr_hit, mem_wr_hit;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic load_use, flush, stall, accept;

  // A slot only counts as a producer if it really writes a non-x0 register
  assign ex_wr_hit  = ex_valid_q & ex_wr_q & (ex_rd_q != 5'd0);
  assign mem_wr_hit = mem_valid_q & mem_wr_q & (mem_rd_q != 5'd0);

  assign rs1_ex  = hz.id_rs1_used_i & ex_wr_hit  & (hz.id_rs1_idx_i == ex_rd_q);
  assign rs2_ex  = hz.id_rs2_used_i & ex_wr_hit  & (hz.id_rs2_idx_i == ex_rd_q);
  assign rs1_mem = hz.id_rs1_used_i & mem_wr_hit & (hz.id_rs1_idx_i == mem_rd_q);
  assign rs2_mem = hz.id_rs2_used_i & mem_wr_hit & (hz.id_rs2_idx_i == mem_rd_q);

  assign load_use = hz.id_valid_i & ex_load_q & (rs1_ex | rs2_ex);
  assign flush    = hz.ex_redirect_i | (state_q == ST_FLUSH);
  // A flushed ID instruction is discarded, so there is nothing to stall for
  assign stall    = load_use & ~flush;
  assign accept   = hz.id_valid_i & ~stall & ~flush;

  assign hz.stall_o       = stall;
  assign hz.flush_id_o    = flush;
  assign hz.fwd_rs1_sel_o = fwd1_q;
  assign hz.fwd_rs2_sel_o = fwd2_q;
  assign stall_cnt_o      = stall_cnt_q;
  assign redirect_cnt_o   = redir_cnt_q;

  // Next slot contents, forwarding selects and saturating event counts
  always_comb begin
    ex_valid_d  = accept;
    ex_rd_d     = hz.id_rd_addr_i;
    ex_wr_d     = hz.id_rd_wr_i;
    ex_load_d   = hz.id_is_load_i;
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_wr_d    = ex_wr_q;

    // Current EX becomes the new MEM and current MEM the new WB; MEM wins
    fwd1_d = 2'd0;
    fwd2_d = 2'd0;
    if (accept) begin
      if (rs1_ex)       fwd1_d = 2'd1;
      else if (rs1_mem) fwd1_d = 2'd2;
      if (rs2_ex)       fwd2_d = 2'd1;
      else if (rs2_mem) fwd2_d = 2'd2;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    redir_cnt_d = redir_cnt_q;
    if (hz.ex_redirect_i && (redir_cnt_q != {CNT_W{1'b1}}))
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  // Slot advance, registered selects and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_wr_q    <= 1'b0;
      fwd1_q      <= 2'd0;
      fwd2_q      <= 2'd0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  // Flush sequencer: the redirect cycle flushes combinationally, FLUSH
  // covers the remaining FLUSH_CYCLES-1 cycles; a new redirect restarts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hz.ex_redirect_i && (FLUSH_CYCLES > 1)) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= FCNT_RELOAD;
          end
        end
        ST_FLUSH: begin
          if (hz.ex_redirect_i) begin
            fcnt_q <= FCNT_RELOAD;
          end else if (fcnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            fcnt_q  <= 4'd0;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          fcnt_q  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CW      = 4;
  localparam int K_STALL = 0;
  localparam int K_FLUSH = 1;
  localparam int K_F1    = 2;
  localparam int K_F2    = 3;
  localparam int K_SCNT  = 4;
  localparam int K_RCNT  = 5;

  typedef struct {
    logic       rst;
    logic       redir;
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } stim_t;

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] redirect_cnt;
  exp_t          sb[$];
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  hazard_ctrl_if hif();

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hz             (hif),
    .stall_cnt_o    (stall_cnt),
    .redirect_cnt_o (redirect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  function automatic stim_t mk(int r, int rd_r, int v, int rd, int wr, int ld,
                               int rs1, int u1, int rs2, int u2);
    stim_t s;
    s.rst = (r != 0);  s.redir = (rd_r != 0); s.v = (v != 0);
    s.rd = 5'(rd);     s.wr = (wr != 0);      s.ld = (ld != 0);
    s.rs1 = 5'(rs1);   s.u1 = (u1 != 0);
    s.rs2 = 5'(rs2);   s.u2 = (u2 != 0);
    return s;
  endfunction

  function automatic stim_t r_rst();   return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t r_idle();  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t r_redir(); return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t r_load(int rd, int base);
    return mk(0, 0, 1, rd, 1, 1, base, 1, 0, 0);
  endfunction
  function automatic stim_t r_alu(int rd, int rs1, int u1, int rs2, int u2);
    return mk(0, 0, 1, rd, 1, 0, rs1, u1, rs2, u2);
  endfunction

  task automatic apply(input stim_t s);
    rst               = s.rst;
    hif.ex_redirect_i = s.redir;
    hif.id_valid_i    = s.v;
    hif.id_rd_addr_i  = s.rd;
    hif.id_rd_wr_i    = s.wr;
    hif.id_is_load_i  = s.ld;
    hif.id_rs1_idx_i  = s.rs1;
    hif.id_rs1_used_i = s.u1;
    hif.id_rs2_idx_i  = s.rs2;
    hif.id_rs2_used_i = s.u2;
  endtask

  task automatic want(input int at, input int kind, input int val, input string tag);
    exp_t e;
    e.at = at; e.kind = kind; e.val = 32'(val); e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_STALL: return {31'd0, hif.stall_o};
      K_FLUSH: return {31'd0, hif.flush_id_o};
      K_F1:    return {30'd0, hif.fwd_rs1_sel_o};
      K_F2:    return {30'd0, hif.fwd_rs2_sel_o};
      K_SCNT:  return 32'(stall_cnt);
      default: return 32'(redirect_cnt);
    endcase
  endfunction

  task automatic test_reset();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(mk(0, 1, 1, 5, 1, 1, 2, 1, 0, 0));
    st.push_back(mk(1, 0, 1, 6, 1, 0, 5, 1, 1, 1));
    st.push_back(r_idle());
    st.push_back(r_idle());
    want(c0 + 1, K_FLUSH, 1, "rst_redir_flush");
    want(c0 + 2, K_RCNT,  1, "rst_pre_rcnt");
    want(c0 + 3, K_FLUSH, 0, "rst_flush");
    want(c0 + 3, K_STALL, 0, "rst_stall");
    want(c0 + 3, K_F1,    0, "rst_f1");
    want(c0 + 3, K_F2,    0, "rst_f2");
    want(c0 + 3, K_SCNT,  0, "rst_scnt");
    want(c0 + 3, K_RCNT,  0, "rst_rcnt");
    want(c0 + 4, K_FLUSH, 0, "rst_flush_after");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_load(5, 2));
    st.push_back(r_alu(6, 5, 1, 1, 1));
    st.push_back(r_alu(6, 5, 1, 1, 1));
    st.push_back(r_idle());
    st.push_back(r_idle());
    st.push_back(r_load(9, 2));
    st.push_back(r_alu(10, 2, 1, 9, 1));
    st.push_back(r_alu(10, 2, 1, 9, 1));
    st.push_back(r_idle());
    want(c0 + 1, K_STALL, 0, "lu_load_nostall");
    want(c0 + 2, K_STALL, 1, "lu_stall");
    want(c0 + 2, K_FLUSH, 0, "lu_noflush");
    want(c0 + 3, K_STALL, 0, "lu_stall_once");
    want(c0 + 3, K_SCNT,  1, "lu_scnt1");
    want(c0 + 3, K_F1,    0, "lu_bubble_f1");
    want(c0 + 4, K_F1,    2, "lu_f1_wb");
    want(c0 + 4, K_F2,    0, "lu_f2_none");
    want(c0 + 7, K_STALL, 1, "lu_rs2_stall");
    want(c0 + 8, K_STALL, 0, "lu_rs2_release");
    want(c0 + 8, K_SCNT,  2, "lu_scnt2");
    want(c0 + 9, K_F1,    0, "lu_rs2_f1");
    want(c0 + 9, K_F2,    2, "lu_rs2_f2_wb");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_alu_chain();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_alu(3, 1, 1, 2, 1));
    st.push_back(r_alu(4, 3, 1, 3, 0));
    st.push_back(r_alu(3, 1, 1, 2, 1));
    st.push_back(r_alu(8, 9, 1, 10, 1));
    st.push_back(r_alu(5, 3, 1, 0, 0));
    st.push_back(r_idle());
    want(c0 + 2, K_STALL, 0, "alu_nostall");
    want(c0 + 3, K_F1,    1, "alu_f1_mem");
    want(c0 + 3, K_F2,    0, "alu_f2_unused");
    want(c0 + 4, K_F1,    0, "alu_indep_f1");
    want(c0 + 5, K_STALL, 0, "alu_gap_nostall");
    want(c0 + 6, K_F1,    2, "alu_gap_f1_wb");
    want(c0 + 6, K_F2,    0, "alu_gap_f2");
    want(c0 + 6, K_SCNT,  0, "alu_scnt");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_double_match();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_alu(7, 0, 0, 0, 0));
    st.push_back(r_alu(7, 0, 0, 0, 0));
    st.push_back(r_alu(9, 7, 1, 7, 1));
    st.push_back(r_idle());
    st.push_back(r_alu(7, 0, 0, 0, 0));
    st.push_back(r_alu(11, 0, 0, 0, 0));
    st.push_back(r_alu(12, 11, 1, 7, 1));
    st.push_back(r_idle());
    want(c0 + 4, K_F1, 1, "dbl_f1_mem_prio");
    want(c0 + 4, K_F2, 1, "dbl_f2_mem_prio");
    want(c0 + 8, K_F1, 1, "mix_f1_mem");
    want(c0 + 8, K_F2, 2, "mix_f2_wb");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_x0();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_load(0, 2));
    st.push_back(r_alu(1, 0, 1, 0, 1));
    st.push_back(r_idle());
    want(c0 + 2, K_STALL, 0, "x0_nostall");
    want(c0 + 3, K_F1,    0, "x0_f1");
    want(c0 + 3, K_F2,    0, "x0_f2");
    want(c0 + 3, K_SCNT,  0, "x0_scnt");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_redirect();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_redir());
    st.push_back(r_alu(13, 0, 0, 0, 0));
    st.push_back(r_alu(14, 13, 1, 0, 0));
    st.push_back(r_redir());
    st.push_back(r_redir());
    st.push_back(r_idle());
    st.push_back(r_idle());
    want(c0 + 1, K_FLUSH, 1, "rd_flush_k");
    want(c0 + 2, K_FLUSH, 1, "rd_flush_k1");
    want(c0 + 2, K_RCNT,  1, "rd_rcnt1");
    want(c0 + 3, K_FLUSH, 0, "rd_flush_k2");
    want(c0 + 4, K_F1,    0, "rd_discarded_f1");
    want(c0 + 4, K_FLUSH, 1, "rd2_flush_k");
    want(c0 + 5, K_FLUSH, 1, "rd2_flush_k1");
    want(c0 + 6, K_FLUSH, 1, "rd2_extend_k2");
    want(c0 + 7, K_FLUSH, 0, "rd2_end");
    want(c0 + 7, K_RCNT,  3, "rd_rcnt3");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_corner();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    st.push_back(r_load(5, 2));
    st.push_back(mk(0, 1, 1, 6, 1, 0, 5, 1, 1, 1));
    st.push_back(r_idle());
    st.push_back(r_redir());
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    st.push_back(r_idle());
    want(c0 + 2, K_STALL, 0, "cc_lu_redir_nostall");
    want(c0 + 2, K_FLUSH, 1, "cc_lu_redir_flush");
    want(c0 + 3, K_SCNT,  0, "cc_scnt_unchanged");
    want(c0 + 3, K_RCNT,  1, "cc_rcnt1");
    want(c0 + 3, K_FLUSH, 1, "cc_flush_tail");
    want(c0 + 4, K_FLUSH, 1, "cc_flush2_k");
    want(c0 + 5, K_FLUSH, 1, "cc_flush2_k1");
    want(c0 + 5, K_RCNT,  2, "cc_rcnt2");
    want(c0 + 6, K_FLUSH, 0, "cc_rst_ends_flush");
    want(c0 + 6, K_RCNT,  0, "cc_rst_rcnt");
    want(c0 + 6, K_SCNT,  0, "cc_rst_scnt");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    int c0 = cyc;
    st.push_back(r_rst());
    for (int k = 0; k < 17; k++) st.push_back(r_redir());
    st.push_back(r_idle());
    want(c0 + 15, K_RCNT, 14, "sat_rcnt14");
    want(c0 + 16, K_RCNT, 15, "sat_rcnt_max");
    want(c0 + 18, K_RCNT, 15, "sat_rcnt_hold");
    want(c0 + 17, K_FLUSH, 1, "sat_flush_held");
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_cmp++;
          if (observe(sb[j].kind) !== sb[j].val) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", sb[j].tag, cyc, observe(sb[j].kind), sb[j].val);
          end
          sb.delete(j);
        end
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  initial begin
    apply(r_rst());
    @(posedge clk); #1;
    cyc = 0;
    test_reset();
    test_load_use();
    test_alu_chain();
    test_double_match();
    test_x0();
    test_redirect();
    test_corner();
    test_saturation();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
